// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the 128-point radix-2 DIF FFT
// address scheduler.
package fft_pkg;

    localparam int N        = 128;
    localparam int LOG2N    = 7;
    localparam int TF_DEPTH = N / 2;
    localparam int AW       = LOG2N;
    localparam int TW_W     = LOG2N - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

endpackage

// File: rtl/fft_bf_addr_calc.sv
// Combinational butterfly address generator: (stage, butterfly index) ->
// top/bottom operand addresses and twiddle index, built from shifts and masks.
module fft_bf_addr_calc #(
    parameter int LOG2N = fft_pkg::LOG2N
) (
    input  logic [2:0]       s_i,
    input  logic [LOG2N-2:0] j_i,
    output logic [LOG2N-1:0] a_o,
    output logic [LOG2N-1:0] b_o,
    output logic [LOG2N-2:0] tw_o
);
    import fft_pkg::*;

    localparam int TWW = LOG2N - 1;
    localparam logic [LOG2N-1:0] HALF = LOG2N'(1) << (LOG2N - 1);

    logic [LOG2N-1:0] jw, span, pos, grp;
    logic [3:0]       sh;

    // sh = log2(span); the group index is j with the in-group offset shifted out
    always_comb begin
        jw   = {1'b0, j_i};
        span = HALF >> s_i;
        pos  = jw & (span - 1'b1);
        sh   = 4'(LOG2N - 1) - {1'b0, s_i};
        grp  = jw >> sh;
        a_o  = (grp << (sh + 4'd1)) | pos;
        b_o  = a_o + span;
        tw_o = TWW'(pos << s_i);
    end

endmodule

// File: rtl/fft_addr_sched.sv
// Stage/butterfly sequencer for the in-place DIF FFT: issues descriptors aligned
// with a 1-cycle twiddle ROM, honours back-pressure, drains between stages.
module fft_addr_sched #(
    parameter int LOG2N      = fft_pkg::LOG2N,
    parameter int BF_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bf_ready,
    output logic [LOG2N-2:0] tf_addr,
    output logic             bf_valid,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [2:0]       stage,
    output logic             last_stage,
    output logic             busy,
    output logic             done
);
    import fft_pkg::*;

    localparam int CW = (BF_LATENCY < 2) ? 1 : $clog2(BF_LATENCY);
    localparam logic [LOG2N-2:0] JMAX  = '1;
    localparam logic [2:0]       SLAST = 3'(LOG2N - 1);
    localparam logic [CW-1:0]    CLAST = CW'(BF_LATENCY - 1);

    state_e           state_q, state_d;
    logic [2:0]       s_q, s_d, stg_q, stg_d;
    logic [LOG2N-2:0] j_q, j_d, tfq_q, tfq_d, tw_c;
    logic [LOG2N-1:0] a_q, a_d, b_q, b_d, a_c, b_c;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d, last_q, last_d;
    logic             issue, accept;

    fft_bf_addr_calc #(.LOG2N(LOG2N)) u_calc (
        .s_i  (s_q),
        .j_i  (j_q),
        .a_o  (a_c),
        .b_o  (b_c),
        .tw_o (tw_c)
    );

    assign accept = vld_q && bf_ready;
    assign issue  = (state_q == RUN) && (!vld_q || bf_ready);

    // While stalled the ROM must re-read the held twiddle, not the next one
    assign tf_addr    = issue ? tw_c : tfq_q;
    assign bf_valid   = vld_q;
    assign addr_a     = a_q;
    assign addr_b     = b_q;
    assign stage      = stg_q;
    assign last_stage = last_q;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        a_d     = a_q;
        b_d     = b_q;
        stg_d   = stg_q;
        last_d  = last_q;
        tfq_d   = tfq_q;

        if (accept) vld_d = 1'b0;
        if (issue) begin
            a_d    = a_c;
            b_d    = b_c;
            stg_d  = s_q;
            last_d = (s_q == SLAST);
            tfq_d  = tw_c;
            vld_d  = 1'b1;
            j_d    = j_q + 1'b1;
        end

        unique case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                s_d     = '0;
                j_d     = '0;
            end
            RUN: if (issue && j_q == JMAX) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            // Gap counting starts only once the stage's last descriptor has left
            DRAIN: if (!vld_q) begin
                if (cnt_q == CLAST) begin
                    if (s_q == SLAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + 1'b1;
                        j_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            stg_q   <= '0;
            last_q  <= 1'b0;
            tfq_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            a_q     <= a_d;
            b_q     <= b_d;
            stg_q   <= stg_d;
            last_q  <= last_d;
            tfq_q   <= tfq_d;
        end
    end

endmodule
